ysyx_23060075_ifu: RTL and testbench
====================================

Name: ysyx_23060075_ifu

Overview:
- Instruction fetch unit. It holds the PC, issues one instruction-memory read per instruction, and presents the fetched instruction and its PC to the decode stage over a valid/ready handshake.
- Decode drives the table-lookup selector with opcode/funct fields of out_inst. This block is the stage directly upstream of the decoder's key-lookup muxes.
- Multi-cycle, non-pipelined: one instruction in flight. The next PC is supplied back by the execute/write-back stage.

Parameters:
- ADDR_LEN, 32, PC and memory address width.
- INST_LEN, 32, instruction width.
- RESET_PC, 32'h8000_0000, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_LEN  request address (= pc).
- imem_resp_valid  in  1  read data valid.
- imem_resp_ready  out  1  fetch accepts read data.
- imem_resp_data  in  INST_LEN  instruction word.
- imem_resp_err  in  1  memory access fault.
- out_valid  out  1  instruction valid to decode.
- out_ready  in  1  decode accepts instruction.
- out_inst  out  INST_LEN  fetched instruction (0 when out_err).
- out_pc  out  ADDR_LEN  PC of out_inst.
- out_err  out  1  fetch fault: access error or misaligned PC.
- npc_valid  in  1  next PC valid from execute/write-back.
- npc  in  ADDR_LEN  next PC.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=S_IDLE, pc=RESET_PC.
  - All valid/ready outputs 0; out_inst=0, out_err=0.
  - out_pc and imem_req_addr read RESET_PC.
- States and transitions:
  - S_IDLE: no outputs asserted; next cycle unconditionally go to S_REQ.
  - S_REQ: imem_req_valid=1, imem_req_addr=pc, held stable until imem_req_ready. On imem_req_valid && imem_req_ready, go to S_RESP.
  - S_RESP: imem_resp_ready=1. On imem_resp_valid:
    - capture inst_r<=imem_resp_data and err_r<=imem_resp_err;
    - if err, inst_r<=0;
    - go to S_OUT.
  - S_OUT: out_valid=1; out_inst/out_pc/out_err stable while out_valid && !out_ready. On out_ready:
    - with npc_valid in the same cycle, take the next-PC action below directly;
    - otherwise go to S_NPC.
  - S_NPC: wait for npc_valid, then take the next-PC action.
- Next-PC action:
  - pc<=npc.
  - If npc[1:0]!=0: no memory request; inst_r<=0, err_r<=1, go to S_OUT.
  - Otherwise: err_r<=0, go to S_REQ.
- npc_valid outside S_NPC, or outside S_OUT-with-out_ready, is ignored. This is a protocol violation and is covered by a bench assertion.
- Latency with zero-wait memory and immediate ready/npc: 1 cycle in S_REQ, 1 in S_RESP, 1 in S_OUT. That is one instruction per 3 cycles.
- out_valid, once raised, never drops without out_ready.
- Handshake signals are decoded from registered state: no combinational path from any input to any valid/ready output.
- Mid-operation reset:
  - Reset asserted in any state returns to S_IDLE with pc=RESET_PC.
  - An outstanding memory response arriving after reset is dropped, because imem_resp_ready=0 outside S_RESP.
- RESET_PC is not checked for alignment.
- Address arithmetic: PC is not incremented here; the next PC is fully supplied by npc.

Decomposition:
- Shared package holds:
  - state encoding S_IDLE/S_REQ/S_RESP/S_OUT/S_NPC (3-bit);
  - RESET_PC default;
  - misalignment mask constant 2'b11.
- One sub-module: ysyx_23060075_reg, a generic width-parameterised register with enable and reset value. It is instanced for pc, inst_r and err_r.

Test Plan:
- Reset release with zero-wait memory returning 32'h0000_0413:
  - imem_req_addr=32'h8000_0000 on the cycle after S_IDLE;
  - out_valid with out_inst=32'h0000_0413, out_pc=32'h8000_0000 three cycles after leaving reset.
- Back-pressure: imem_req_ready low 4 cycles, then out_ready low 3 cycles. Address and out_* stay stable throughout; exactly one request and one decode transfer.
- Simultaneous: out_ready=1 with npc_valid=1, npc=32'h8000_0004 in S_OUT. Next cycle is S_REQ with imem_req_addr=32'h8000_0004; S_NPC is never entered.
- Misaligned npc=32'h8000_0006: no imem_req_valid; out_valid=1, out_err=1, out_inst=0, out_pc=32'h8000_0006.
- Memory fault: imem_resp_err=1 with data 32'hdead_beef. Then out_err=1, out_inst=0; the next aligned npc clears out_err on the following fetch.
- Reset pulse while in S_RESP with resp pending:
  - state returns to S_IDLE and pc to 32'h8000_0000;
  - the late imem_resp_valid is not accepted (imem_resp_ready=0);
  - the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_23060075_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_t            : fetch FSM state encoding (3-bit)
//   RESET_PC_DEFAULT   : default PC loaded on reset
//   MISALIGN_MASK      : low PC bits that must be zero for a legal fetch
//   is_misaligned()    : true when a PC violates 4-byte alignment
package ysyx_23060075_ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_OUT  = 3'd3,
    S_NPC  = 3'd4
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [1:0]  MISALIGN_MASK    = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |(lsb & MISALIGN_MASK);
  endfunction

endpackage

// File: rtl/ysyx_23060075_reg.sv
// Generic register with load enable and a parameterised reset value.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, loads RST_VAL
//   en    : load enable
//   d     : next value
//   q     : registered value
module ysyx_23060075_reg #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_23060075_ifu.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read
// per instruction and hands the instruction plus its PC to decode. Only one
// instruction is in flight; the next PC comes back from execute/write-back.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      : memory read request (addr = pc)
//   imem_resp_valid/ready/data/err : memory read response
//   out_valid/ready/inst/pc/err    : instruction to decode (inst = 0 on err)
//   npc_valid, npc                 : next PC from execute/write-back
module ysyx_23060075_ifu
  import ysyx_23060075_ifu_pkg::*;
#(
  parameter int                  ADDR_LEN = 32,
  parameter int                  INST_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_LEN-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  output logic                imem_resp_ready,
  input  logic [INST_LEN-1:0] imem_resp_data,
  input  logic                imem_resp_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_LEN-1:0] out_inst,
  output logic [ADDR_LEN-1:0] out_pc,
  output logic                out_err,
  input  logic                npc_valid,
  input  logic [ADDR_LEN-1:0] npc
);

  state_t              state;
  state_t              state_nxt;
  state_t              npc_target;
  logic                resp_fire;
  logic                take_npc;
  logic                npc_mis;
  logic [ADDR_LEN-1:0] pc;
  logic [INST_LEN-1:0] inst_r;
  logic                err_r;
  logic                inst_en;
  logic [INST_LEN-1:0] inst_d;
  logic                err_en;
  logic                err_d;

  assign npc_mis    = is_misaligned(npc[1:0]);
  assign npc_target = npc_mis ? S_OUT : S_REQ;
  assign resp_fire  = (state == S_RESP) && imem_resp_valid;
  // npc is only honoured while decode is accepting or while parked in S_NPC.
  assign take_npc   = npc_valid && (((state == S_OUT) && out_ready) || (state == S_NPC));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (imem_req_ready)  state_nxt = S_RESP;
      S_RESP:  if (imem_resp_valid) state_nxt = S_OUT;
      S_OUT:   if (out_ready)       state_nxt = npc_valid ? npc_target : S_NPC;
      S_NPC:   if (npc_valid)       state_nxt = npc_target;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so no input
  // reaches a valid/ready output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      imem_req_valid  <= 1'b0;
      imem_resp_ready <= 1'b0;
      out_valid       <= 1'b0;
    end else begin
      state           <= state_nxt;
      imem_req_valid  <= (state_nxt == S_REQ);
      imem_resp_ready <= (state_nxt == S_RESP);
      out_valid       <= (state_nxt == S_OUT);
    end
  end

  // A faulting response or a misaligned npc both present a zero instruction.
  assign inst_en = resp_fire || (take_npc && npc_mis);
  assign inst_d  = (resp_fire && !imem_resp_err) ? imem_resp_data : '0;
  assign err_en  = resp_fire || take_npc;
  assign err_d   = resp_fire ? imem_resp_err : npc_mis;

  ysyx_23060075_reg #(.DATA_W(ADDR_LEN), .RST_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (take_npc),
    .d     (npc),
    .q     (pc)
  );

  ysyx_23060075_reg #(.DATA_W(INST_LEN), .RST_VAL('0)) u_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (inst_en),
    .d     (inst_d),
    .q     (inst_r)
  );

  ysyx_23060075_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (err_en),
    .d     (err_d),
    .q     (err_r)
  );

  assign imem_req_addr = pc;
  assign out_pc        = pc;
  assign out_inst      = inst_r;
  assign out_err       = err_r;

endmodule

// File: tb/tb_ysyx_23060075_ifu.sv
module tb_ysyx_23060075_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;
  logic        npc_valid;
  logic [31:0] npc;

  always #5 clk = ~clk;

  ysyx_23060075_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_err         (out_err),
    .npc_valid       (npc_valid),
    .npc             (npc)
  );

  int checks = 0;
  int errors = 0;
  int req_fires = 0;
  int resp_fires = 0;
  int out_fires = 0;
  bit npc_wait = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs are driven at the falling edge; handshakes are tallied from the
  // values the next rising edge will see, then time advances one cycle.
  task automatic step();
    if (imem_req_valid && imem_req_ready) req_fires++;
    if (imem_resp_valid && imem_resp_ready) resp_fires++;
    if (out_valid && out_ready) out_fires++;
    if (rst_n && npc_valid)
      assert ((out_valid && out_ready) || npc_wait) else $error("npc_valid outside accept window");
    if (!rst_n || npc_valid) npc_wait = 0;
    else if (out_valid && out_ready) npc_wait = 1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_npc(input logic [31:0] cur);
    logic [31:0] v;
    v = {cur[31:2], 2'b00};
    case ($urandom_range(0, 5))
      0, 1, 2: v = v + 32'd4;
      3:       begin v = $urandom; v[1:0] = 2'b00; end
      4:       begin v = $urandom; v[1:0] = 2'($urandom_range(1, 3)); end
      default: v = v - 32'd8;
    endcase
    return v;
  endfunction

  logic [31:0] d2, s_inst, s_pc;
  int r0, o0, rs0;

  // Transaction-level reference state for the random phase.
  logic [31:0] exp_pc, exp_inst, exp_out_pc, mem_data;
  bit          exp_err, mem_err, expect_req, expect_out, mem_busy, need_npc;
  int          mem_delay, idle;
  bit          req_f, resp_f, out_f, npc_f;

  initial begin
    rst_n = 1'b1;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; imem_resp_err = 0;
    out_ready = 0; npc_valid = 0; npc = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk_eq("rst_req_valid", imem_req_valid, 0);
    chk_eq("rst_resp_ready", imem_resp_ready, 0);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_out_inst", out_inst, 0);
    chk_eq("rst_out_err", out_err, 0);
    chk_eq("rst_out_pc", out_pc, 32'h8000_0000);
    chk_eq("rst_req_addr", imem_req_addr, 32'h8000_0000);

    // Zero-wait memory straight out of reset.
    imem_req_ready = 1; imem_resp_valid = 1; imem_resp_data = 32'h0000_0413;
    rst_n = 1'b1;
    step();
    chk_eq("first_req_valid", imem_req_valid, 1);
    chk_eq("first_req_addr", imem_req_addr, 32'h8000_0000);
    step();
    chk_eq("first_resp_ready", imem_resp_ready, 1);
    step();
    chk_eq("first_out_valid", out_valid, 1);
    chk_eq("first_out_inst", out_inst, 32'h0000_0413);
    chk_eq("first_out_pc", out_pc, 32'h8000_0000);
    chk_eq("first_out_err", out_err, 0);

    // Decode accepts and npc arrives in the same cycle: straight to a request.
    out_ready = 1; npc_valid = 1; npc = 32'h8000_0004;
    imem_req_ready = 0; imem_resp_valid = 0;
    step();
    out_ready = 0; npc_valid = 0;
    chk_eq("simul_req_valid", imem_req_valid, 1);
    chk_eq("simul_req_addr", imem_req_addr, 32'h8000_0004);
    chk_eq("simul_out_valid", out_valid, 0);

    // Back-pressure on the request, then on decode.
    r0 = req_fires; o0 = out_fires;
    repeat (4) begin
      step();
      chk_eq("bp_req_valid", imem_req_valid, 1);
      chk_eq("bp_req_addr", imem_req_addr, 32'h8000_0004);
    end
    imem_req_ready = 1;
    step();
    chk_eq("bp_resp_ready", imem_resp_ready, 1);
    chk_eq("bp_req_dropped", imem_req_valid, 0);
    d2 = $urandom;
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = d2; imem_resp_err = 0;
    step();
    imem_resp_valid = 0;
    chk_eq("bp_out_valid", out_valid, 1);
    chk_eq("bp_out_inst", out_inst, d2);
    chk_eq("bp_out_pc", out_pc, 32'h8000_0004);
    repeat (2) begin
      step();
      chk_eq("bp_hold_valid", out_valid, 1);
      chk_eq("bp_hold_inst", out_inst, d2);
      chk_eq("bp_hold_pc", out_pc, 32'h8000_0004);
      chk_eq("bp_hold_err", out_err, 0);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk_eq("bp_req_count", req_fires - r0, 1);
    chk_eq("bp_out_count", out_fires - o0, 1);
    step();
    chk_eq("npc_wait_out_valid", out_valid, 0);
    chk_eq("npc_wait_req_valid", imem_req_valid, 0);

    // Misaligned npc: fault reported without touching memory.
    npc_valid = 1; npc = 32'h8000_0006;
    step();
    npc_valid = 0;
    chk_eq("mis_req_valid", imem_req_valid, 0);
    chk_eq("mis_out_valid", out_valid, 1);
    chk_eq("mis_out_err", out_err, 1);
    chk_eq("mis_out_inst", out_inst, 0);
    chk_eq("mis_out_pc", out_pc, 32'h8000_0006);
    step();
    chk_eq("mis_hold_req_valid", imem_req_valid, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    npc_valid = 1; npc = 32'h8000_0008;
    step();
    npc_valid = 0;
    chk_eq("realign_req_addr", imem_req_addr, 32'h8000_0008);

    // Memory access fault.
    imem_req_ready = 1;
    step();
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = 32'hdead_beef; imem_resp_err = 1;
    step();
    imem_resp_valid = 0; imem_resp_err = 0;
    chk_eq("fault_out_err", out_err, 1);
    chk_eq("fault_out_inst", out_inst, 0);
    chk_eq("fault_out_pc", out_pc, 32'h8000_0008);
    out_ready = 1; npc_valid = 1; npc = 32'h8000_000c;
    step();
    out_ready = 0; npc_valid = 0;
    imem_req_ready = 1;
    step();
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = 32'h1234_5678;
    step();
    imem_resp_valid = 0;
    chk_eq("clear_out_err", out_err, 0);
    chk_eq("clear_out_inst", out_inst, 32'h1234_5678);
    chk_eq("clear_out_pc", out_pc, 32'h8000_000c);

    // Reset while waiting on a response.
    out_ready = 1; npc_valid = 1; npc = 32'h8000_0010;
    step();
    out_ready = 0; npc_valid = 0;
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    chk_eq("pre_rst_resp_ready", imem_resp_ready, 1);
    chk_eq("pre_rst_addr", imem_req_addr, 32'h8000_0010);
    rs0 = resp_fires;
    #2 rst_n = 1'b0;
    #1;
    npc_wait = 0;
    chk_eq("mid_rst_resp_ready", imem_resp_ready, 0);
    chk_eq("mid_rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk_eq("mid_rst_out_pc", out_pc, 32'h8000_0000);
    imem_resp_valid = 1; imem_resp_data = 32'h0bad_f00d;
    @(negedge clk);
    chk_eq("late_resp_ready_rst", imem_resp_ready, 0);
    rst_n = 1'b1;
    step();
    chk_eq("restart_req_valid", imem_req_valid, 1);
    chk_eq("restart_req_addr", imem_req_addr, 32'h8000_0000);
    chk_eq("late_resp_ready_req", imem_resp_ready, 0);
    imem_resp_valid = 0; imem_req_ready = 1;
    step();
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = 32'h0000_0413;
    step();
    imem_resp_valid = 0;
    chk_eq("late_resp_count", resp_fires - rs0, 1);
    chk_eq("restart_out_inst", out_inst, 32'h0000_0413);
    chk_eq("restart_out_pc", out_pc, 32'h8000_0000);

    // Randomised traffic against the transaction-level model.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    exp_pc = 32'h8000_0000; exp_inst = 0; exp_out_pc = 0; exp_err = 0;
    expect_req = 1; expect_out = 0; mem_busy = 0; need_npc = 0;
    mem_delay = 0; mem_data = 0; mem_err = 0; idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk_eq("rnd_req_valid", imem_req_valid, expect_req);
      if (imem_req_valid) chk_eq("rnd_req_addr", imem_req_addr, exp_pc);
      chk_eq("rnd_resp_ready", imem_resp_ready, mem_busy);
      chk_eq("rnd_out_valid", out_valid, expect_out);
      if (out_valid) begin
        chk_eq("rnd_out_inst", out_inst, exp_inst);
        chk_eq("rnd_out_pc", out_pc, exp_out_pc);
        chk_eq("rnd_out_err", out_err, exp_err);
      end

      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (mem_busy && mem_delay > 0) begin
        imem_resp_valid = 0;
        mem_delay--;
      end else begin
        imem_resp_valid = mem_busy;
      end
      imem_resp_data = imem_resp_valid ? mem_data : $urandom;
      imem_resp_err  = imem_resp_valid ? mem_err : 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      npc_valid = 0;
      npc = $urandom;
      if (expect_out && out_ready && $urandom_range(0, 2) == 0) begin
        npc_valid = 1; npc = gen_npc(exp_pc);
      end else if (need_npc && $urandom_range(0, 1) == 1) begin
        npc_valid = 1; npc = gen_npc(exp_pc);
      end

      req_f  = expect_req && imem_req_ready;
      resp_f = mem_busy && imem_resp_valid;
      out_f  = expect_out && out_ready;
      npc_f  = npc_valid;
      if (req_f) begin
        expect_req = 0; mem_busy = 1;
        mem_delay = $urandom_range(0, 3);
        mem_data = $urandom;
        mem_err = ($urandom_range(0, 7) == 0);
      end
      if (resp_f) begin
        mem_busy = 0; expect_out = 1;
        exp_inst = mem_err ? 32'h0 : mem_data;
        exp_err = mem_err; exp_out_pc = exp_pc;
      end
      if (out_f) begin
        expect_out = 0; need_npc = 1;
      end
      if (npc_f) begin
        need_npc = 0; exp_pc = npc;
        if (npc[1:0] != 2'b00) begin
          expect_out = 1; exp_inst = 0; exp_err = 1; exp_out_pc = npc;
        end else begin
          expect_req = 1;
        end
      end
      if (req_f || resp_f || out_f || npc_f) idle = 0;
      else idle++;
      if (idle > 40) begin
        chk_eq("rnd_progress", idle, 0);
        break;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
